// File: rtl/psw_pkg.sv
// Shared constants for the push-switch front end.
// Switch bit positions, default debounce timing and a counter-width helper.
package psw_pkg;

    localparam int PSW_N_SW       = 20;
    localparam int PSW_TICK_DIV   = 250000;
    localparam int PSW_STABLE_CNT = 4;

    localparam int SW_STEP = 4;
    localparam int SW_MEM  = 9;
    localparam int SW_IO   = 14;
    localparam int SW_VIEW = 19;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psw_debounce_ch.sv
// One debounce channel: stability counter, level register
// and registered press/release pulses.
module psw_debounce_ch
    import psw_pkg::*;
#(
    parameter int STABLE_CNT = PSW_STABLE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sample,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ = (sample != level);
    assign accept = tick && differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= accept & sample;
            rel   <= accept & ~sample;
            if (tick) begin
                if (!differ) begin
                    cnt <= '0;
                end else if (accept) begin
                    level <= sample;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/psw_debounce.sv
// Push-switch front end: 2-FF synchroniser, shared sample prescaler
// and one debounce channel per switch.
module psw_debounce
    import psw_pkg::*;
#(
    parameter int N_SW       = PSW_N_SW,
    parameter int TICK_DIV   = PSW_TICK_DIV,
    parameter int STABLE_CNT = PSW_STABLE_CNT,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] psw_in,
    output logic [N_SW-1:0] psw_out,
    output logic [N_SW-1:0] psw_level,
    output logic [N_SW-1:0] psw_rel
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [N_SW-1:0] IDLE = {N_SW{ACTIVE_LOW}};

    logic [N_SW-1:0] sync_q1;
    logic [N_SW-1:0] sync_q2;
    logic [N_SW-1:0] sample;
    logic [PW-1:0]   pre;
    logic            tick;

    // Flops reset to the released level so reset release is not a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= IDLE;
            sync_q2 <= IDLE;
        end else begin
            sync_q1 <= psw_in;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = sync_q2 ^ IDLE;
    assign tick   = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        psw_debounce_ch #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .sample(sample[i]),
            .level (psw_level[i]),
            .press (psw_out[i]),
            .rel   (psw_rel[i])
        );
    end

endmodule
